// File: rtl/dmem_arbiter_if.sv
// Bundle of the pipeline, secondary-requester and data-memory signals around dmem_arbiter.
// The arbiter uses the slave modport; the requesters and memory use the master modport.
interface dmem_arbiter_if;
    // Pipeline MEM stage
    logic        p_mem_read;
    logic        p_mem_write;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [31:0] p_rdata;
    logic        stall_pipeline;

    // Secondary requester (debug loader / DMA)
    logic        s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_ack;
    logic [31:0] s_rdata;

    // Data memory
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  p_mem_read, p_mem_write, p_addr, p_wdata,
        output p_rdata, stall_pipeline,
        input  s_req, s_we, s_addr, s_wdata,
        output s_ack, s_rdata,
        output mem_re, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p_mem_read, p_mem_write, p_addr, p_wdata,
        input  p_rdata, stall_pipeline,
        output s_req, s_we, s_addr, s_wdata,
        input  s_ack, s_rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the pipeline has priority, and a starvation counter forces a one-cycle
// pipeline stall so the secondary requester gets a slot. It also subtracts the data-segment base.
module dmem_arbiter #(
    parameter logic [31:0] ADDR_BASE    = 32'h1001_0000,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    dmem_arbiter_if.slave   bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {IDLE, ACK} state_t;

    state_t      state, stateNext;
    logic [3:0]  starveCnt, starveNext;
    logic [31:0] sRdata, sRdataNext;
    logic        pAct, forceGnt, pOwn, sOwn;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            starveCnt <= 4'd0;
            sRdata    <= 32'd0;
        end else begin
            state     <= stateNext;
            starveCnt <= starveNext;
            sRdata    <= sRdataNext;
        end
    end

    // Ownership is gated with reset so the memory sees no access while reset is low.
    always_comb begin
        pAct     = bus.p_mem_read | bus.p_mem_write;
        forceGnt = reset & (state == IDLE) & bus.s_req & pAct & (starveCnt == LIMIT);
        pOwn     = reset & pAct & ~forceGnt;
        sOwn     = reset & (forceGnt | (~pAct & (state == IDLE) & bus.s_req));
    end

    always_comb begin
        bus.mem_re         = 1'b0;
        bus.mem_we         = 1'b0;
        bus.mem_addr       = 32'd0;
        bus.mem_wdata      = 32'd0;
        bus.p_rdata        = 32'd0;
        bus.stall_pipeline = forceGnt;
        if (pOwn) begin
            bus.mem_we    = bus.p_mem_write;
            bus.mem_re    = bus.p_mem_read & ~bus.p_mem_write;
            bus.mem_addr  = bus.p_addr - ADDR_BASE;
            bus.mem_wdata = bus.p_wdata;
            bus.p_rdata   = bus.mem_rdata;
        end else if (sOwn) begin
            bus.mem_we    = bus.s_we;
            bus.mem_re    = ~bus.s_we;
            bus.mem_addr  = bus.s_addr - ADDR_BASE;
            bus.mem_wdata = bus.s_wdata;
        end
    end

    // ACK always lasts one cycle, so grants are at least two cycles apart.
    always_comb begin
        stateNext  = IDLE;
        starveNext = starveCnt;
        sRdataNext = sRdata;
        if (sOwn) begin
            stateNext = ACK;
            if (!bus.s_we)
                sRdataNext = bus.mem_rdata;
        end
        if (!bus.s_req || sOwn)
            starveNext = 4'd0;
        else if ((state == IDLE) && pOwn && (starveCnt != 4'hF))
            starveNext = starveCnt + 4'd1;
    end

    assign bus.s_ack   = (state == ACK);
    assign bus.s_rdata = sRdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter sharing the single-port data memory between the pipeline MEM stage and one secondary requester, such as a debug loader or an I/O DMA engine.
- The pipeline normally has priority.
- A starvation counter guarantees the secondary requester an access slot. To provide it, the block stalls the whole pipeline for one cycle.
- The block sits between the EX/MEM pipeline register and the data memory. It also applies the data-segment base-address translation.

## Interface
Parameters:
- ADDR_BASE, 32'h1001_0000, data-segment base subtracted from every requester address before it reaches memory.
- STARVE_LIMIT, 4, number of consecutive denied secondary cycles before a forced grant; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- p_mem_read  in  1  pipeline MEM-stage read request (from EX/MEM register).
- p_mem_write  in  1  pipeline MEM-stage write request.
- p_addr  in  32  pipeline byte address (ALU result).
- p_wdata  in  32  pipeline write data.
- p_rdata  out  32  read data returned to the MEM/WB register.
- stall_pipeline  out  1  when 1, PC, IF/ID, ID/EX, EX/MEM and MEM/WB hold their values this cycle.
- s_req  in  1  secondary request; held high until s_ack.
- s_we  in  1  secondary write (1) / read (0); stable while s_req is high.
- s_addr  in  32  secondary byte address.
- s_wdata  in  32  secondary write data.
- s_ack  out  1  one-cycle completion pulse.
- s_rdata  out  32  registered secondary read data; valid when s_ack=1.
- mem_re, mem_we  out  1 each  data memory controls.
- mem_addr  out  32  translated address.
- mem_wdata  out  32  data memory write data.
- mem_rdata  in  32  data memory read data (combinational read, synchronous write).

## Operation
- The FSM has two states:
  - IDLE: secondary requests are accepted.
  - ACK: s_ack=1. The s_req sampled in this state is ignored, because it is the completed request still held. The FSM always returns to IDLE next cycle.
- p_act = p_mem_read | p_mem_write.
- starve_cnt is a 4-bit counter.
- Ownership is decided combinationally each cycle, in priority order:
  1. force = (state==IDLE) & s_req & p_act & (starve_cnt==STARVE_LIMIT). The secondary owns memory and stall_pipeline=1.
  2. Otherwise, if p_act, the pipeline owns memory.
  3. Otherwise, if state==IDLE & s_req, the secondary owns memory.
  4. Otherwise nobody owns memory: mem_re=mem_we=0, mem_addr=0, mem_wdata=0.
- When the pipeline owns memory:
  - mem_we=p_mem_write and mem_re=p_mem_read & ~p_mem_write (write wins if both are set).
  - mem_addr=p_addr-ADDR_BASE (modulo 2^32); mem_wdata=p_wdata.
  - p_rdata=mem_rdata.
- When the pipeline does not own memory, p_rdata=0.
- When the secondary owns memory:
  - mem_we=s_we, mem_re=~s_we, mem_addr=s_addr-ADDR_BASE, mem_wdata=s_wdata.
  - At the clock edge, s_rdata<=mem_rdata on reads; s_rdata holds its value on writes.
  - state<=ACK.
- starve_cnt behaviour:
  - Increments (saturating) in cycles where state==IDLE, s_req=1 and the pipeline owns memory.
  - Clears on any secondary grant, and whenever s_req=0.
- A stalled pipeline access is not performed. It is re-presented the next cycle unchanged, and then wins because starve_cnt=0.

## Timing
- All outputs reset to 0:
  - state=IDLE, starve_cnt=0, s_ack=0, s_rdata=0, stall_pipeline=0.
  - The memory controls are 0 while reset=0.
- Pipeline latency is 0 cycles: it uses the same-cycle combinational path to memory, with the write committed at the clock edge.
- Secondary latency is grant cycle + 1: s_ack and s_rdata are valid on the cycle after the grant.
  - Best case (memory free): s_req high in cycle N, s_ack high in N+1.
  - Worst case under continuous pipeline traffic: s_ack in N+STARVE_LIMIT+1.
- Secondary throughput is at most one transaction per 2 cycles, because the ACK state blocks acceptance.
- stall_pipeline is high for exactly one cycle per forced grant and is never high in two consecutive cycles.
- Reset asserted mid-transaction drops the transaction: no s_ack, and any write already committed at an earlier edge stays.
- Deasserting s_req while in IDLE before a grant cancels the request without an ack.

## Test plan
- **Pipeline only:** p_mem_write=1, p_addr=32'h1001_0008, p_wdata=32'hDEAD_BEEF. Then read the same address → mem_addr=8, p_rdata=32'hDEAD_BEEF, stall_pipeline=0 throughout.
- **Secondary only:** s_req=1, s_we=0, s_addr=32'h1001_0008 → grant in cycle N, s_ack=1 and s_rdata=32'hDEAD_BEEF in N+1, s_ack=0 in N+2.
- **Starvation:** p_mem_read held 1 continuously, STARVE_LIMIT=4, s_req raised in cycle 0 → pipeline owns cycles 0-3, forced grant with stall_pipeline=1 in cycle 4, s_ack in cycle 5, starve_cnt=0 after.
- **Simultaneous, counter below limit:** p_mem_write and s_req both rise in the same cycle → pipeline write commits first. The secondary is granted the first cycle p_act=0, and s_ack follows one cycle later.
- **Back-to-back secondary:** s_req held high across the ack → a second grant occurs no earlier than the cycle after ACK, and s_ack pulses are never adjacent.
- **Reset mid-transaction:** reset=0 during the grant cycle → s_ack never pulses; s_rdata, stall_pipeline and starve_cnt read 0; normal operation resumes after reset=1.
